feature_stream_tx: RTL and testbench

Frame-level transmitter that produces the pixel-serial feature stream consumed by the 3-line line buffer. On Start, it reads a Height x Width feature map from on-chip feature memory. The memory has a 1-cycle read latency and holds one P_CH-channel pixel vector per word. The block emits the map in raster order, one pixel per cycle, with an optional 1-pixel zero border for same-padded 3x3 windows. The stream has no backpressure: the downstream line buffer accepts every valid beat.

---
 rtl/feature_stream_tx.sv | 163 ++++++++++++++++
 tb/tb_feature_stream_tx.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/feature_stream_tx.sv
// rtl/feature_stream_tx.sv - raster-order pixel stream transmitter with optional zero border
//
// Purpose: on Start, reads a Height x Width feature map from a 1-cycle-latency
// memory (one P_CH-channel pixel per word) and emits it in raster order, one
// pixel per cycle, optionally surrounded by a 1-pixel zero border.
//
// Ports:
//   clk, reset            - clock (rising edge), asynchronous active-high reset
//   Start                 - frame start request, sampled only in IDLE
//   Height, Width         - unpadded map size, latched on accepted Start
//   Pad_En                - add zero border, latched on accepted Start
//   Base_Addr             - address of pixel (0,0), latched on accepted Start
//   Mem_Rd_En, Mem_Addr   - memory read strobe / address
//   Mem_Rd_Data           - read data, valid the cycle after Mem_Rd_En
//   Feature_Outputs       - pixel vector, zero when not valid
//   Feature_Outputs_Valid - beat qualifier
//   Busy                  - frame in progress (SCAN or FLUSH)
//   Done                  - single-cycle pulse coincident with the last beat
module feature_stream_tx #(
  parameter int DWIDTH = 8,
  parameter int P_CH   = 32,
  parameter int AWIDTH = 10,
  parameter int HWIDTH = 10
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     Start,
  input  logic [HWIDTH-1:0]        Height,
  input  logic [HWIDTH-1:0]        Width,
  input  logic                     Pad_En,
  input  logic [AWIDTH-1:0]        Base_Addr,
  output logic                     Mem_Rd_En,
  output logic [AWIDTH-1:0]        Mem_Addr,
  input  logic [DWIDTH*P_CH-1:0]   Mem_Rd_Data,
  output logic [DWIDTH*P_CH-1:0]   Feature_Outputs,
  output logic                     Feature_Outputs_Valid,
  output logic                     Busy,
  output logic                     Done
);

  localparam int CW = HWIDTH + 1;

  typedef enum logic [1:0] {IDLE, SCAN, FLUSH} state_t;

  state_t             state_q, state_d;
  logic [HWIDTH-1:0]  height_q, height_d;
  logic [HWIDTH-1:0]  width_q, width_d;
  logic               pad_q, pad_d;
  logic [CW-1:0]      ho_q, ho_d;
  logic [CW-1:0]      wo_q, wo_d;
  logic [CW-1:0]      row_q, row_d;
  logic [CW-1:0]      col_q, col_d;
  logic [AWIDTH-1:0]  addr_q, addr_d;
  logic [AWIDTH-1:0]  last_addr_q, last_addr_d;
  logic               valid_q, valid_d;
  logic               interior_q, interior_d;
  logic               interior;
  logic               rd_en;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      height_q    <= '0;
      width_q     <= '0;
      pad_q       <= 1'b0;
      ho_q        <= '0;
      wo_q        <= '0;
      row_q       <= '0;
      col_q       <= '0;
      addr_q      <= '0;
      last_addr_q <= '0;
      valid_q     <= 1'b0;
      interior_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      height_q    <= height_d;
      width_q     <= width_d;
      pad_q       <= pad_d;
      ho_q        <= ho_d;
      wo_q        <= wo_d;
      row_q       <= row_d;
      col_q       <= col_d;
      addr_q      <= addr_d;
      last_addr_q <= last_addr_d;
      valid_q     <= valid_d;
      interior_q  <= interior_d;
    end
  end

  // With padding, rows/cols 0 and Ho-1/Wo-1 are the zero border.
  always_comb begin
    interior = !pad_q ||
               (row_q >= CW'(1) && row_q <= {1'b0, height_q} &&
                col_q >= CW'(1) && col_q <= {1'b0, width_q});
  end

  always_comb begin
    state_d     = state_q;
    height_d    = height_q;
    width_d     = width_q;
    pad_d       = pad_q;
    ho_d        = ho_q;
    wo_d        = wo_q;
    row_d       = row_q;
    col_d       = col_q;
    addr_d      = addr_q;
    last_addr_d = last_addr_q;
    valid_d     = 1'b0;
    interior_d  = 1'b0;
    rd_en       = 1'b0;

    case (state_q)
      IDLE: begin
        if (Start) begin
          height_d = Height;
          width_d  = Width;
          pad_d    = Pad_En;
          ho_d     = {1'b0, Height} + {{(CW-2){1'b0}}, Pad_En, 1'b0};
          wo_d     = {1'b0, Width}  + {{(CW-2){1'b0}}, Pad_En, 1'b0};
          row_d    = '0;
          col_d    = '0;
          addr_d   = Base_Addr;
          state_d  = (Height != '0 && Width != '0) ? SCAN : FLUSH;
        end
      end
      SCAN: begin
        valid_d    = 1'b1;
        interior_d = interior;
        if (interior) begin
          rd_en       = 1'b1;
          last_addr_d = addr_q;
          addr_d      = addr_q + AWIDTH'(1);
        end
        if (col_q == wo_q - CW'(1)) begin
          col_d = '0;
          if (row_q == ho_q - CW'(1)) begin
            state_d = FLUSH;
          end else begin
            row_d = row_q + CW'(1);
          end
        end else begin
          col_d = col_q + CW'(1);
        end
      end
      FLUSH: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Address shows the running counter while reading; otherwise it holds the
  // last issued address so border cycles do not toggle the bus.
  assign Mem_Rd_En             = rd_en;
  assign Mem_Addr              = rd_en ? addr_q : last_addr_q;
  assign Feature_Outputs       = (valid_q && interior_q) ? Mem_Rd_Data : '0;
  assign Feature_Outputs_Valid = valid_q;
  assign Busy                  = (state_q != IDLE);
  assign Done                  = (state_q == FLUSH);

endmodule

// File: tb/tb_feature_stream_tx.sv
// tb/tb_feature_stream_tx.sv - directed self-checking bench for feature_stream_tx
module tb_feature_stream_tx;

  localparam int DWIDTH = 8;
  localparam int P_CH   = 32;
  localparam int AWIDTH = 10;
  localparam int HWIDTH = 10;
  localparam int DW     = DWIDTH * P_CH;

  logic              clk;
  logic              reset;
  logic              Start;
  logic [HWIDTH-1:0] Height;
  logic [HWIDTH-1:0] Width;
  logic              Pad_En;
  logic [AWIDTH-1:0] Base_Addr;
  logic              Mem_Rd_En;
  logic [AWIDTH-1:0] Mem_Addr;
  logic [DW-1:0]     Mem_Rd_Data;
  logic [DW-1:0]     Feature_Outputs;
  logic              Feature_Outputs_Valid;
  logic              Busy;
  logic              Done;

  int checks = 0;
  int errors = 0;
  int rd_cnt;
  int beat_cnt;

  feature_stream_tx #(
    .DWIDTH(DWIDTH), .P_CH(P_CH), .AWIDTH(AWIDTH), .HWIDTH(HWIDTH)
  ) dut (
    .clk(clk),
    .reset(reset),
    .Start(Start),
    .Height(Height),
    .Width(Width),
    .Pad_En(Pad_En),
    .Base_Addr(Base_Addr),
    .Mem_Rd_En(Mem_Rd_En),
    .Mem_Addr(Mem_Addr),
    .Mem_Rd_Data(Mem_Rd_Data),
    .Feature_Outputs(Feature_Outputs),
    .Feature_Outputs_Valid(Feature_Outputs_Valid),
    .Busy(Busy),
    .Done(Done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory word at address a is byte (a[7:0]+1) replicated across channels.
  always @(posedge clk) begin
    if (Mem_Rd_En) Mem_Rd_Data <= {P_CH{Mem_Addr[7:0] + 8'd1}};
  end

  function automatic logic [DW-1:0] rep(input logic [7:0] b);
    return {P_CH{b}};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_cycle(input string tag, input logic rd, input logic [AWIDTH-1:0] addr,
                           input logic valid, input logic [7:0] dbyte,
                           input logic busy, input logic done);
    chk({tag, ".rd"}, DW'(Mem_Rd_En), DW'(rd));
    if (rd) chk({tag, ".addr"}, DW'(Mem_Addr), DW'(addr));
    chk({tag, ".valid"}, DW'(Feature_Outputs_Valid), DW'(valid));
    chk({tag, ".data"}, Feature_Outputs, valid ? rep(dbyte) : '0);
    chk({tag, ".busy"}, DW'(Busy), DW'(busy));
    chk({tag, ".done"}, DW'(Done), DW'(done));
    rd_cnt   += int'(Mem_Rd_En);
    beat_cnt += int'(Feature_Outputs_Valid);
  endtask

  // Unpadded 2x3 frame starting at base: 6 reads at t+1..t+6, beats t+2..t+7,
  // Done at t+7. Called at t+1; returns at t+8.
  task automatic frame_2x3(input string tag, input logic [AWIDTH-1:0] base);
    rd_cnt = 0;
    beat_cnt = 0;
    for (int k = 1; k <= 7; k++) begin
      chk_cycle(tag, k <= 6, base + AWIDTH'(k - 1), k >= 2,
                base[7:0] + 8'd1 + 8'(k - 2), 1'b1, k == 7);
      step();
    end
    chk({tag, ".reads"}, DW'(rd_cnt), DW'(6));
    chk({tag, ".beats"}, DW'(beat_cnt), DW'(6));
  endtask

  function automatic int pad_word(input int p);
    case (p)
      5:  return 1;
      6:  return 2;
      9:  return 3;
      10: return 4;
      default: return 0;
    endcase
  endfunction

  logic [AWIDTH-1:0] wrap_addr  [4] = '{10'h3FE, 10'h3FF, 10'h000, 10'h001};
  logic [7:0]        wrap_bytes [4] = '{8'hFF, 8'h00, 8'h01, 8'h02};

  initial begin
    reset = 1'b1; Start = 1'b0; Height = '0; Width = '0; Pad_En = 1'b0; Base_Addr = '0;
    Mem_Rd_Data = '0;
    #1;
    chk_cycle("reset", 1'b0, '0, 1'b0, 8'h00, 1'b0, 1'b0);
    chk("reset.addr", DW'(Mem_Addr), '0);
    step();
    reset = 1'b0;
    step();

    // 1: plain 2x3 from 0x010; config scrambled after acceptance
    Height = 10'd2; Width = 10'd3; Pad_En = 1'b0; Base_Addr = 10'h010; Start = 1'b1;
    step();
    Start = 1'b0; Height = 10'd7; Width = 10'd9; Pad_En = 1'b1; Base_Addr = 10'h155;
    frame_2x3("plain", 10'h010);
    chk_cycle("plain.idle", 1'b0, '0, 1'b0, 8'h00, 1'b0, 1'b0);
    chk("plain.addr_hold", DW'(Mem_Addr), DW'(10'h015));

    // 2: padded 2x2 from 0x000 -> 16 beats, interior at 5,6,9,10
    Height = 10'd2; Width = 10'd2; Pad_En = 1'b1; Base_Addr = 10'h000; Start = 1'b1;
    step();
    Start = 1'b0;
    rd_cnt = 0; beat_cnt = 0;
    for (int k = 1; k <= 18; k++) begin
      int wr, wb;
      wr = (k <= 16) ? pad_word(k - 1) : 0;
      wb = (k >= 2 && k <= 17) ? pad_word(k - 2) : 0;
      chk_cycle("pad", wr != 0, AWIDTH'(wr - 1), k >= 2 && k <= 17, 8'(wb),
                k <= 17, k == 17);
      step();
    end
    chk("pad.reads", DW'(rd_cnt), DW'(4));
    chk("pad.beats", DW'(beat_cnt), DW'(16));

    // 3: address wrap 1x4 from 0x3FE
    Height = 10'd1; Width = 10'd4; Pad_En = 1'b0; Base_Addr = 10'h3FE; Start = 1'b1;
    step();
    Start = 1'b0;
    rd_cnt = 0; beat_cnt = 0;
    for (int k = 1; k <= 6; k++) begin
      chk_cycle("wrap", k <= 4, wrap_addr[(k <= 4) ? k - 1 : 0], k >= 2 && k <= 5,
                wrap_bytes[(k >= 2 && k <= 5) ? k - 2 : 0], k <= 5, k == 5);
      step();
    end
    chk("wrap.reads", DW'(rd_cnt), DW'(4));
    chk("wrap.beats", DW'(beat_cnt), DW'(4));

    // 4: Start held high through a 2x3 frame from 0x040
    Height = 10'd2; Width = 10'd3; Pad_En = 1'b0; Base_Addr = 10'h040; Start = 1'b1;
    step();
    frame_2x3("hold", 10'h040);
    chk_cycle("hold.gap", 1'b0, '0, 1'b0, 8'h00, 1'b0, 1'b0);
    step();
    chk_cycle("hold.restart", 1'b1, 10'h040, 1'b0, 8'h00, 1'b1, 1'b0);
    Start = 1'b0;
    step();
    chk_cycle("hold.first_beat", 1'b1, 10'h041, 1'b1, 8'h41, 1'b1, 1'b0);
    for (int k = 0; k < 6; k++) step();
    chk("hold.drained", DW'(Busy), DW'(0));

    // 5: zero width with padding
    Height = 10'd5; Width = 10'd0; Pad_En = 1'b1; Base_Addr = 10'h100; Start = 1'b1;
    step();
    Start = 1'b0;
    chk_cycle("zero.flush", 1'b0, '0, 1'b0, 8'h00, 1'b1, 1'b1);
    step();
    chk_cycle("zero.idle", 1'b0, '0, 1'b0, 8'h00, 1'b0, 1'b0);

    // 6: async reset at 3rd beat of a 4x4 frame, then a clean frame
    Height = 10'd4; Width = 10'd4; Pad_En = 1'b0; Base_Addr = 10'h020; Start = 1'b1;
    step();
    Start = 1'b0;
    step(); step(); step();
    chk_cycle("abort.beat3", 1'b1, 10'h023, 1'b1, 8'h23, 1'b1, 1'b0);
    #2;
    reset = 1'b1;
    #1;
    chk_cycle("abort.async", 1'b0, '0, 1'b0, 8'h00, 1'b0, 1'b0);
    chk("abort.async.addr", DW'(Mem_Addr), '0);
    step();
    chk_cycle("abort.held", 1'b0, '0, 1'b0, 8'h00, 1'b0, 1'b0);
    reset = 1'b0;
    step();
    chk_cycle("abort.released", 1'b0, '0, 1'b0, 8'h00, 1'b0, 1'b0);
    chk("abort.released.addr", DW'(Mem_Addr), '0);
    Start = 1'b1;
    step();
    Start = 1'b0;
    rd_cnt = 0; beat_cnt = 0;
    for (int k = 1; k <= 18; k++) begin
      chk_cycle("refrm", k <= 16, 10'h020 + AWIDTH'(k - 1), k >= 2 && k <= 17,
                8'h21 + 8'(k - 2), k <= 17, k == 17);
      step();
    end
    chk("refrm.reads", DW'(rd_cnt), DW'(16));
    chk("refrm.beats", DW'(beat_cnt), DW'(16));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
